// File: rtl/s16x4_sram_bridge_if.sv
// CPU-side bus bundle for the 16-bit to 8-bit SRAM bridge.
// Signals: adr_i, we_i, cyc_i, stb_i, sel_i, dat_i (to bridge); dat_o, ack_o (from bridge).
interface s16x4_sram_bridge_if;
  logic [15:1] adr_i;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic [1:0]  sel_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack_o;

  modport master (
    output adr_i, we_i, cyc_i, stb_i,
    output sel_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, we_i, cyc_i, stb_i,
    input  sel_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/s16x4_sram_bridge.sv
// Bridges a 16-bit CPU bus onto an 8-bit async SRAM, one byte lane at a time.
// Ports: clk_i, res_i, bus (slave), sram_adr_o/dat_o/dat_i/dat_oe_o, sram_ce_n/oe_n/we_n_o.
module s16x4_sram_bridge #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        res_i,
  s16x4_sram_bridge_if.slave bus,
  output logic [15:0] sram_adr_o,
  output logic [7:0]  sram_dat_o,
  input  logic [7:0]  sram_dat_i,
  output logic        sram_dat_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RECOVER,
    ACK
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [15:1] adr_q;
  logic        we_q;
  logic [1:0]  sel_q;
  logic [15:0] wdat_q;
  logic [15:0] rd_q;
  logic        lane_q;
  logic [3:0]  cnt_q;
  logic        abort_q;

  logic req;
  logic last_strb;
  logic more_lane;

  assign req       = bus.cyc_i & bus.stb_i;
  assign last_strb = (cnt_q == 4'd0);
  assign more_lane = ~lane_q & sel_q[1];

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (bus.sel_i == 2'b00) state_d = ACK;
          else                    state_d = STROBE;
        end
      end
      STROBE: begin
        if (last_strb) state_d = RECOVER;
      end
      RECOVER: begin
        if (abort_q)        state_d = IDLE;
        else if (more_lane) state_d = STROBE;
        else                state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at the IDLE latch; later input
  // changes cannot disturb the transaction in flight.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      wdat_q  <= '0;
      rd_q    <= '0;
      lane_q  <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            adr_q   <= bus.adr_i;
            we_q    <= bus.we_i;
            sel_q   <= bus.sel_i;
            wdat_q  <= bus.dat_i;
            rd_q    <= '0;
            lane_q  <= (bus.sel_i == 2'b10);
            cnt_q   <= WS;
            abort_q <= 1'b0;
          end
        end
        STROBE: begin
          if (!bus.cyc_i) abort_q <= 1'b1;
          if (last_strb) begin
            if (!we_q) begin
              if (lane_q) rd_q[15:8] <= sram_dat_i;
              else        rd_q[7:0]  <= sram_dat_i;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RECOVER: begin
          if (!abort_q && more_lane) begin
            lane_q <= 1'b1;
            cnt_q  <= WS;
          end
        end
        ACK: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Address, data and pad enable stay put through RECOVER
  // so a write sees hold time after we_n rises.
  always_comb begin
    bus.ack_o     = (state_q == ACK);
    bus.dat_o     = '0;
    sram_adr_o    = {adr_q, lane_q};
    sram_dat_o    = lane_q ? wdat_q[15:8] : wdat_q[7:0];
    sram_dat_oe_o = 1'b0;
    sram_ce_n_o   = 1'b1;
    sram_oe_n_o   = 1'b1;
    sram_we_n_o   = 1'b1;
    unique case (state_q)
      IDLE: begin
      end
      STROBE: begin
        sram_ce_n_o   = 1'b0;
        sram_oe_n_o   = we_q;
        sram_we_n_o   = ~we_q;
        sram_dat_oe_o = we_q;
      end
      RECOVER: begin
        sram_dat_oe_o = we_q;
      end
      ACK: begin
        bus.dat_o = rd_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_s16x4_sram_bridge.sv
// Directed testbench for s16x4_sram_bridge with W=0 and W=1 instances.
// Byte-wide SRAM model shared by both instances; one instance active at a time.
module tb_s16x4_sram_bridge;

  logic clk;
  logic res;

  logic [15:1] adr;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [1:0]  sel;
  logic [15:0] wdat;
  int          d_sel;

  logic [7:0] mem [65536];

  s16x4_sram_bridge_if bus0();
  s16x4_sram_bridge_if bus1();

  logic [15:0] sa0, sa1;
  logic [7:0]  sd0, sd1, si0, si1;
  logic        doe0, doe1, ce0, ce1, oe0, oe1, we0, we1;

  assign bus0.adr_i = adr;
  assign bus0.we_i  = we;
  assign bus0.sel_i = sel;
  assign bus0.dat_i = wdat;
  assign bus0.cyc_i = cyc && (d_sel == 0);
  assign bus0.stb_i = stb && (d_sel == 0);
  assign bus1.adr_i = adr;
  assign bus1.we_i  = we;
  assign bus1.sel_i = sel;
  assign bus1.dat_i = wdat;
  assign bus1.cyc_i = cyc && (d_sel == 1);
  assign bus1.stb_i = stb && (d_sel == 1);

  assign si0 = mem[sa0];
  assign si1 = mem[sa1];

  s16x4_sram_bridge #(.WAIT_STATES(0)) u_w0 (
    .clk_i(clk), .res_i(res), .bus(bus0),
    .sram_adr_o(sa0), .sram_dat_o(sd0),
    .sram_dat_i(si0), .sram_dat_oe_o(doe0),
    .sram_ce_n_o(ce0), .sram_oe_n_o(oe0),
    .sram_we_n_o(we0)
  );

  s16x4_sram_bridge #(.WAIT_STATES(1)) u_w1 (
    .clk_i(clk), .res_i(res), .bus(bus1),
    .sram_adr_o(sa1), .sram_dat_o(sd1),
    .sram_dat_i(si1), .sram_dat_oe_o(doe1),
    .sram_ce_n_o(ce1), .sram_oe_n_o(oe1),
    .sram_we_n_o(we1)
  );

  always @(posedge clk) begin
    if (!ce0 && !we0) mem[sa0] <= sd0;
    if (!ce1 && !we1) mem[sa1] <= sd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        o_ack, o_doe, o_ce_n, o_oe_n, o_we_n;
  logic [15:0] o_dat, o_adr;
  logic [7:0]  o_sdat;

  always_comb begin
    o_ack  = bus0.ack_o;
    o_dat  = bus0.dat_o;
    o_adr  = sa0;
    o_sdat = sd0;
    o_doe  = doe0;
    o_ce_n = ce0;
    o_oe_n = oe0;
    o_we_n = we0;
    if (d_sel == 1) begin
      o_ack  = bus1.ack_o;
      o_dat  = bus1.dat_o;
      o_adr  = sa1;
      o_sdat = sd1;
      o_doe  = doe1;
      o_ce_n = ce1;
      o_oe_n = oe1;
      o_we_n = we1;
    end
  end

  int total;
  int passed;

  int          ack_cyc, n_ack, oe_lo, we_lo, ce_lo;
  int          even_strb, odd_strb, doe_cnt, overlap;
  logic [15:0] rd_val;
  logic [7:0]  wr_byte;

  task automatic run_txn(
    input int d, input logic [15:1] a, input logic w,
    input logic [1:0] s, input logic [15:0] wd,
    input int ncyc, input int drop_at
  );
    d_sel = d; adr = a; we = w; sel = s; wdat = wd;
    cyc = 1'b1; stb = 1'b1;
    ack_cyc = -1; n_ack = 0; rd_val = '0;
    oe_lo = 0; we_lo = 0; ce_lo = 0; doe_cnt = 0;
    even_strb = 0; odd_strb = 0; overlap = 0; wr_byte = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (c == drop_at) begin cyc = 1'b0; stb = 1'b0; end
      if (!o_ce_n) begin
        ce_lo++;
        if (o_adr[0]) odd_strb++;
        else          even_strb++;
      end
      if (!o_oe_n) oe_lo++;
      if (!o_we_n) begin we_lo++; wr_byte = o_sdat; end
      if (!o_we_n && !o_oe_n) overlap++;
      if (o_doe) doe_cnt++;
      if (o_ack) begin
        n_ack++;
        if (ack_cyc < 0) begin ack_cyc = c; rd_val = o_dat; end
        cyc = 1'b0; stb = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    d_sel = 1;
    #12;
    total++;
    if (o_ack !== 1'b0 || o_dat !== 16'h0)
      $display("FAIL reset_bus: ack=%b dat=%h want 0/0000", o_ack, o_dat);
    else passed++;
    total++;
    if (o_adr !== 16'h0 || o_sdat !== 8'h0 || o_doe !== 1'b0)
      $display("FAIL reset_sram: adr=%h dat=%h oe=%b want 0", o_adr, o_sdat, o_doe);
    else passed++;
    total++;
    if ({o_ce_n, o_oe_n, o_we_n} !== 3'b111)
      $display("FAIL reset_strobes: got %b want 111", {o_ce_n, o_oe_n, o_we_n});
    else passed++;
    @(posedge clk); #1;
    res = 1'b0;
  endtask

  task automatic test_word_read;
    run_txn(1, 15'h1234, 1'b0, 2'b11, 16'h0, 10, 0);
    total++;
    if (ack_cyc !== 7 || n_ack !== 1)
      $display("FAIL word_read_ack: cyc=%0d n=%0d want 7/1", ack_cyc, n_ack);
    else passed++;
    total++;
    if (rd_val !== 16'hABCD)
      $display("FAIL word_read_data: got %h want abcd", rd_val);
    else passed++;
    total++;
    if (oe_lo !== 4 || even_strb !== 2 || odd_strb !== 2)
      $display("FAIL word_read_strobe: oe=%0d ev=%0d od=%0d want 4/2/2",
               oe_lo, even_strb, odd_strb);
    else passed++;
    total++;
    if (overlap !== 0 || we_lo !== 0)
      $display("FAIL word_read_we: ov=%0d we=%0d want 0/0", overlap, we_lo);
    else passed++;
  endtask

  task automatic test_byte_read;
    run_txn(1, 15'h0100, 1'b0, 2'b01, 16'h0, 8, 0);
    total++;
    if (ack_cyc !== 4 || rd_val !== 16'h0077)
      $display("FAIL byte_read: cyc=%0d dat=%h want 4/0077", ack_cyc, rd_val);
    else passed++;
  endtask

  task automatic test_high_write;
    run_txn(0, 15'h0010, 1'b1, 2'b10, 16'h5A00, 6, 0);
    total++;
    if (ack_cyc !== 3 || n_ack !== 1)
      $display("FAIL hwrite_ack: cyc=%0d n=%0d want 3/1", ack_cyc, n_ack);
    else passed++;
    total++;
    if (we_lo !== 1 || ce_lo !== 1 || odd_strb !== 1)
      $display("FAIL hwrite_strobe: we=%0d ce=%0d od=%0d want 1/1/1",
               we_lo, ce_lo, odd_strb);
    else passed++;
    total++;
    if (wr_byte !== 8'h5A || mem[16'h0021] !== 8'h5A)
      $display("FAIL hwrite_data: bus=%h mem=%h want 5a", wr_byte, mem[16'h0021]);
    else passed++;
    total++;
    if (doe_cnt !== 2 || oe_lo !== 0)
      $display("FAIL hwrite_oe: doe=%0d oe=%0d want 2/0", doe_cnt, oe_lo);
    else passed++;
    total++;
    if (rd_val !== 16'h0)
      $display("FAIL hwrite_rdata: got %h want 0000", rd_val);
    else passed++;
  endtask

  task automatic test_sel_none;
    run_txn(1, 15'h0555, 1'b1, 2'b00, 16'hFFFF, 5, 0);
    total++;
    if (ack_cyc !== 1 || n_ack !== 1)
      $display("FAIL sel00_ack: cyc=%0d n=%0d want 1/1", ack_cyc, n_ack);
    else passed++;
    total++;
    if (ce_lo !== 0 || doe_cnt !== 0)
      $display("FAIL sel00_ce: ce=%0d doe=%0d want 0/0", ce_lo, doe_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int a1, a2, acks, consec;
    logic prev;
    logic [15:0] d1, d2, adr7;
    d_sel = 0; adr = 15'h0040; we = 1'b0; sel = 2'b11;
    cyc = 1'b1; stb = 1'b1;
    a1 = -1; a2 = -1; acks = 0; consec = 0; prev = 1'b0;
    d1 = '0; d2 = '0; adr7 = '0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 7) adr7 = o_adr;
      if (o_ack) begin
        acks++;
        if (prev) consec++;
        if (a1 < 0) begin
          a1 = c; d1 = o_dat; adr = 15'h0041;
        end else if (a2 < 0) begin
          a2 = c; d2 = o_dat; cyc = 1'b0; stb = 1'b0;
        end
      end
      prev = o_ack;
    end
    total++;
    if (a1 !== 5 || d1 !== 16'h2211)
      $display("FAIL b2b_first: cyc=%0d dat=%h want 5/2211", a1, d1);
    else passed++;
    total++;
    if (adr7 !== 16'h0082)
      $display("FAIL b2b_latch: adr=%h want 0082", adr7);
    else passed++;
    total++;
    if (a2 !== 11 || d2 !== 16'h4433)
      $display("FAIL b2b_second: cyc=%0d dat=%h want 11/4433", a2, d2);
    else passed++;
    total++;
    if (acks !== 2 || consec !== 0)
      $display("FAIL b2b_count: acks=%0d consec=%0d want 2/0", acks, consec);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int acks;
    d_sel = 1; adr = 15'h0200; we = 1'b1; sel = 2'b11;
    wdat = 16'hBEEF; cyc = 1'b1; stb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    total++;
    if (o_we_n !== 1'b0 || o_adr !== 16'h0401)
      $display("FAIL rst_mid_pre: we_n=%b adr=%h want 0/0401", o_we_n, o_adr);
    else passed++;
    #2 res = 1'b1;
    #1;
    total++;
    if ({o_ce_n, o_oe_n, o_we_n} !== 3'b111 || o_doe !== 1'b0)
      $display("FAIL rst_mid_async: strb=%b doe=%b want 111/0",
               {o_ce_n, o_oe_n, o_we_n}, o_doe);
    else passed++;
    acks = 0;
    @(posedge clk); #1;
    res = 1'b0; cyc = 1'b0; stb = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (o_ack) acks++;
      @(posedge clk); #1;
    end
    total++;
    if (acks !== 0)
      $display("FAIL rst_mid_noack: acks=%0d want 0", acks);
    else passed++;
    total++;
    if (mem[16'h0400] !== 8'hEF || mem[16'h0401] !== 8'h00)
      $display("FAIL rst_mid_mem: lo=%h hi=%h want ef/00",
               mem[16'h0400], mem[16'h0401]);
    else passed++;
    run_txn(1, 15'h0200, 1'b0, 2'b11, 16'h0, 10, 0);
    total++;
    if (ack_cyc !== 7 || rd_val !== 16'h00EF)
      $display("FAIL rst_mid_after: cyc=%0d dat=%h want 7/00ef", ack_cyc, rd_val);
    else passed++;
  endtask

  task automatic test_abort;
    run_txn(1, 15'h0300, 1'b0, 2'b11, 16'h0, 12, 1);
    total++;
    if (n_ack !== 0)
      $display("FAIL abort_ack: acks=%0d want 0", n_ack);
    else passed++;
    total++;
    if (oe_lo !== 2 || even_strb !== 2 || odd_strb !== 0)
      $display("FAIL abort_strobe: oe=%0d ev=%0d od=%0d want 2/2/0",
               oe_lo, even_strb, odd_strb);
    else passed++;
    run_txn(1, 15'h0300, 1'b0, 2'b00, 16'h0, 4, 0);
    total++;
    if (ack_cyc !== 1)
      $display("FAIL abort_idle: cyc=%0d want 1", ack_cyc);
    else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    res = 1'b1; d_sel = 1;
    adr = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    sel = 2'b00; wdat = '0;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    mem[16'h2468] <= 8'hCD;
    mem[16'h2469] <= 8'hAB;
    mem[16'h0200] <= 8'h77;
    mem[16'h0201] <= 8'h99;
    mem[16'h0080] <= 8'h11;
    mem[16'h0081] <= 8'h22;
    mem[16'h0082] <= 8'h33;
    mem[16'h0083] <= 8'h44;
    mem[16'h0600] <= 8'h05;
    mem[16'h0601] <= 8'h06;
    test_reset;
    test_word_read;
    test_byte_read;
    test_high_write;
    test_sel_none;
    test_back_to_back;
    test_reset_mid;
    test_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/s16x4_sram_bridge.md
S16X4_SRAM_BRIDGE -- requirements
Module: s16x4_sram_bridge

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra strobe cycles per SRAM byte access; legal range 0..15.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port res_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port adr_i  input  15  CPU word address [15:1].
REQ-005 SHALL have port we_i  input  1  CPU write enable.
REQ-006 SHALL have port cyc_i  input  1  CPU bus cycle in progress.
REQ-007 SHALL have port stb_i  input  1  CPU strobe; a request is cyc_i & stb_i.
REQ-008 SHALL have port sel_i  input  2  byte lane select; bit0 = dat[7:0], bit1 = dat[15:8].
REQ-009 SHALL have port dat_i  input  16  CPU write data.
REQ-010 SHALL have port dat_o  output  16  read data returned to the CPU.
REQ-011 SHALL have port ack_o  output  1  cycle complete.
REQ-012 SHALL have port sram_adr_o  output  16  SRAM byte address.
REQ-013 SHALL have port sram_dat_o  output  8  SRAM write byte.
REQ-014 SHALL have port sram_dat_i  input  8  SRAM read byte.
REQ-015 SHALL have port sram_dat_oe_o  output  1  data pad drive enable; high while writing.
REQ-016 SHALL have port sram_ce_n_o  output  1  SRAM chip enable, active low.
REQ-017 SHALL have port sram_oe_n_o  output  1  SRAM output enable, active low.
REQ-018 SHALL have port sram_we_n_o  output  1  SRAM write enable, active low.

Function
REQ-019 SHALL implement FSM states IDLE, STROBE, RECOVER and ACK.
REQ-020 IDLE, request seen and ack_o low: SHALL latch adr_i, we_i, sel_i and dat_i.
- If sel_i == 00: next state is ACK, with no SRAM access.
- Otherwise: next state is STROBE on the lowest selected lane, with the wait counter loaded with WAIT_STATES.
REQ-021 Lane order SHALL be lane 0 first, then lane 1; unselected lanes are skipped.
REQ-022 Byte address SHALL be {adr[15:1], lane}, with lane 0 = even byte and lane 1 = odd byte.
REQ-023 STROBE SHALL drive the following, for WAIT_STATES+1 cycles:
- sram_ce_n_o = 0.
- sram_oe_n_o = we.
- sram_we_n_o = ~we.
- sram_dat_oe_o = we.
- sram_dat_o = the selected byte of the latched data.
REQ-024 On the last STROBE cycle of a read, the block SHALL capture sram_dat_i into the matching byte of the read register.
REQ-025 RECOVER SHALL last one cycle:
- ce_n, oe_n and we_n all high.
- sram_adr_o, sram_dat_o and sram_dat_oe_o held from STROBE, to give write hold time.
- Next state is STROBE on the remaining lane if one is pending, otherwise ACK.
REQ-026 ACK SHALL assert ack_o for exactly one cycle and then return to IDLE.
- dat_o holds the assembled read value while ack_o is high.
- Unselected lanes and writes return 0.
REQ-027 ack_o SHALL never be high for two consecutive cycles; a request present in the cycle after ACK starts a new transaction.
REQ-028 Latency, counting the request cycle as cycle 0 and W = WAIT_STATES:
- ack_o high in cycle 2W+5 for sel 11.
- ack_o high in cycle W+3 for sel 01 or 10.
- ack_o high in cycle 1 for sel 00.
REQ-029 If cyc_i drops during STROBE, the block SHALL complete that byte through RECOVER and then go to IDLE without asserting ack_o; the pending lane is discarded.
REQ-030 Inputs changing after the IDLE latch SHALL have no effect on the current transaction.
REQ-031 In IDLE, sram_ce_n_o, sram_oe_n_o and sram_we_n_o SHALL be high and sram_dat_oe_o low.
REQ-032 sram_we_n_o and sram_oe_n_o SHALL never be low in the same cycle.

Reset
REQ-033 While res_i is high, the block SHALL immediately, and independently of clk_i, force:
- state = IDLE, ack_o = 0, dat_o = 0.
- sram_adr_o = 0, sram_dat_o = 0, sram_dat_oe_o = 0.
- sram_ce_n_o = sram_oe_n_o = sram_we_n_o = 1.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no ack_o; the first request after res_i falls SHALL be handled normally.

Verification
REQ-035 Word read, W=1: adr_i=15'h1234, sel=11, SRAM[0x2468]=0xCD, SRAM[0x2469]=0xAB.
- Required: ack_o only in cycle 7, dat_o=16'hABCD.
- Required: sram_adr_o = 0x2468 and then 0x2469.
- Required: oe_n low 2 cycles per byte.
REQ-036 High-byte write, W=0: adr_i=15'h0010, sel=10, dat_i=16'h5A00.
- Required: one STROBE cycle at 0x0021 with sram_dat_o=0x5A and we_n low for 1 cycle.
- Required: dat_oe stays high through RECOVER; ack_o in cycle 3.
REQ-037 sel=00 with we=1: ack_o in cycle 1, and ce_n never goes low.
REQ-038 Back-to-back reads with cyc_i held high, W=0:
- Required: each transaction ack_o exactly one cycle.
- Required: second address latched in the cycle after ACK.
- Required: no double ack.
REQ-039 Assert res_i asynchronously during the second STROBE of a word write.
- Required: we_n, ce_n and oe_n go high before the next clock edge.
- Required: no ack_o.
- Required: a subsequent word read, W=1, completes in cycle 7.
REQ-040 Drop cyc_i during the first STROBE of a word read.
- Required: that byte finishes through RECOVER, the second lane is never strobed, and ack_o stays 0.
